c2c_master_reset_seq: RTL and testbench
=======================================

// Module: c2c_master_reset_seq
//
// PURPOSE
//   Master-side partner of the slave reset delay. Asserts the local Chip2Chip
//   master reset and pulses the cross-board reset line to the slave board.
//   After the pulse, releases the master and waits for link_up to be stable.
//   Retries on timeout up to MAX_RETRIES, then latches a failure.
//   Sits between board reset/software control and the C2C master + Aurora core.
//
// PARAMETERS
//   SLAVE_PULSE_CYCLES  1000       cycles slave_reset_out and reset_out held high
//   LINK_TIMEOUT        3000000    cycles allowed for link_up after master release (> slave 2.5M delay)
//   STABLE_CYCLES       1000       consecutive cycles link_up must be high to declare link good
//   MAX_RETRIES         3          timeout retries before entering FAIL
//
// PORTS
//   clock            in   1  system clock
//   resetn           in   1  synchronous, active-low reset
//   sw_reset_req     in   1  single-cycle request to re-run the full sequence
//   link_up          in   1  C2C/Aurora link status, asynchronous; synchronized internally
//   reset_out        out  1  active-high reset to local C2C master
//   slave_reset_out  out  1  active-high reset pulse to slave board (drives slave reset_in)
//   link_good        out  1  high while in UP
//   link_fail        out  1  high while in FAIL (sticky until sw_reset_req or resetn)
//   retry_count      out  4  timeouts in current sequence; cleared on every sequence start
//   drop_count       out  8  link losses while UP; saturates at 255; cleared only by resetn
//
// BEHAVIOUR
//   - resetn low, sampled on clock edge, forces:
//     - state=PULSE, counter=SLAVE_PULSE_CYCLES-1;
//     - reset_out=1, slave_reset_out=1, link_good=0, link_fail=0;
//     - retry_count=0, drop_count=0, stable counter=0.
//   - resetn mid-sequence aborts immediately; sequence restarts from PULSE.
//   - link_up passes through a 2-flop synchronizer (link_s) before use; adds 2 cycles latency.
//   - PULSE:
//     - reset_out=1, slave_reset_out=1; counter decrements.
//     - At 0 -> WAIT, counter=LINK_TIMEOUT-1, stable=0.
//     - Pulse width is exactly SLAVE_PULSE_CYCLES.
//   - WAIT:
//     - reset_out=0, slave_reset_out=0.
//     - link_s high: stable++; link_s low: stable=0.
//     - stable reaching STABLE_CYCLES-1 with link_s high -> UP.
//     - Otherwise counter at 0 (timeout): if retry_count<MAX_RETRIES, retry_count++ -> PULSE; else -> FAIL.
//     - Stability completing in the same cycle as timeout: UP wins.
//   - UP:
//     - link_good=1.
//     - link_s low -> link_good=0 next cycle; drop_count++ (saturating); retry_count=0 -> PULSE.
//   - FAIL: link_fail=1, reset_out=0. Exits only via sw_reset_req or resetn.
//   - sw_reset_req, any state:
//     - -> PULSE with retry_count=0, link_good=0, link_fail=0.
//     - Overrides a timeout, stability completion or link drop in the same cycle.
//     - A drop coinciding with sw_reset_req does not increment drop_count.
//   - Outputs are registered; each output changes in the cycle after its state transition.
//   - One shared down-counter, width $clog2(max(SLAVE_PULSE_CYCLES, LINK_TIMEOUT)).
//   - Stable counter width $clog2(STABLE_CYCLES+1).
//
// STRUCTURE
//   - c2c_reset_pkg: state encodings (PULSE, WAIT, UP, FAIL) and a counter-width helper function.
//     Shared with the slave reset manager testbench.
//   - Sub-module c2c_sync_bit: 2-flop synchronizer for link_up, reusable elsewhere.
//   - All else is one always block plus output registers.
//
// TESTING  (bench params: SLAVE_PULSE_CYCLES=10, LINK_TIMEOUT=100, STABLE_CYCLES=5, MAX_RETRIES=2)
//   1. resetn low 3 cycles then high; link_up high at cycle 40 -> slave_reset_out high exactly
//      10 cycles; link_good=1 after 5 stable cycles + 2 sync cycles; retry_count=0.
//   2. link_up never high -> 3 pulses total; retry_count 1 then 2; link_fail=1 after 3rd timeout,
//      reset_out=0, held indefinitely.
//   3. In FAIL, sw_reset_req for 1 cycle -> link_fail=0, retry_count=0, new 10-cycle pulse.
//   4. link_up glitches high 3 cycles, then low, then high steady -> no UP on glitch; UP only
//      after 5 continuous cycles.
//   5. In UP, drop link_up 1 cycle -> link_good=0, drop_count=1, new pulse; repeat 300 times
//      -> drop_count stays at 255.
//   6. resetn low mid-WAIT, and sw_reset_req coincident with timeout -> immediate restart to
//      PULSE; retry_count=0 in both cases.

Source files
------------

// File: rtl/c2c_reset_pkg.sv
// Shared definitions for the Chip2Chip reset sequencers (master sequencer and
// the slave reset manager bench).
package c2c_reset_pkg;

  typedef enum logic [1:0] {
    PULSE = 2'd0,
    WAIT  = 2'd1,
    UP    = 2'd2,
    FAIL  = 2'd3
  } seq_state_t;

  // Width of a down-counter that must be loadable with (larger of a, b) - 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/c2c_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level signal.
module c2c_sync_bit (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/c2c_master_reset_seq.sv
// Master-side C2C reset sequencer: pulses the slave board reset, releases the
// local master, and waits for a stable link with bounded retries.
//
//   state | meaning
//   PULSE | local master and slave board held in reset for the pulse window
//   WAIT  | resets released, waiting for link_up to stay high long enough
//   UP    | link good; any loss restarts the sequence
//   FAIL  | retries exhausted; parked until sw_reset_req or resetn
module c2c_master_reset_seq
  import c2c_reset_pkg::*;
#(
  parameter int SLAVE_PULSE_CYCLES = 1000,
  parameter int LINK_TIMEOUT       = 3000000,
  parameter int STABLE_CYCLES      = 1000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       sw_reset_req,
  input  logic       link_up,
  output logic       reset_out,
  output logic       slave_reset_out,
  output logic       link_good,
  output logic       link_fail,
  output logic [3:0] retry_count,
  output logic [7:0] drop_count
);

  localparam int CW = cnt_width(SLAVE_PULSE_CYCLES, LINK_TIMEOUT);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [CW-1:0] PULSE_LOAD   = CW'(SLAVE_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LINK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_DONE  = SW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  seq_state_t    state;
  logic          link_s;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stable;

  c2c_sync_bit u_link_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (link_up),
    .q      (link_s)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= PULSE;
      cnt             <= PULSE_LOAD;
      stable          <= '0;
      retry_count     <= '0;
      drop_count      <= '0;
      reset_out       <= 1'b1;
      slave_reset_out <= 1'b1;
      link_good       <= 1'b0;
      link_fail       <= 1'b0;
    end else if (sw_reset_req) begin
      // Software restart beats any timeout, lock or drop decided this cycle.
      state           <= PULSE;
      cnt             <= PULSE_LOAD;
      stable          <= '0;
      retry_count     <= '0;
      reset_out       <= 1'b1;
      slave_reset_out <= 1'b1;
      link_good       <= 1'b0;
      link_fail       <= 1'b0;
    end else begin
      unique case (state)
        PULSE: begin
          if (cnt == '0) begin
            state           <= WAIT;
            cnt             <= TIMEOUT_LOAD;
            stable          <= '0;
            reset_out       <= 1'b0;
            slave_reset_out <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          stable <= link_s ? stable + 1'b1 : '0;
          // Lock is tested before timeout so a lock on the last cycle wins.
          if (link_s && stable == STABLE_DONE) begin
            state     <= UP;
            link_good <= 1'b1;
          end else if (cnt == '0) begin
            if (retry_count < RETRY_MAX) begin
              retry_count     <= retry_count + 1'b1;
              state           <= PULSE;
              cnt             <= PULSE_LOAD;
              reset_out       <= 1'b1;
              slave_reset_out <= 1'b1;
            end else begin
              state     <= FAIL;
              link_fail <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        UP: begin
          if (!link_s) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            retry_count     <= '0;
            state           <= PULSE;
            cnt             <= PULSE_LOAD;
            reset_out       <= 1'b1;
            slave_reset_out <= 1'b1;
            link_good       <= 1'b0;
          end
        end
        FAIL: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c2c_master_reset_seq.sv
// Bench for c2c_master_reset_seq: directed scenarios plus random stimulus,
// checked every cycle against a phase/elapsed-time model of the sequence.
module tb_c2c_master_reset_seq;

  localparam int SP = 10;
  localparam int LT = 100;
  localparam int SC = 5;
  localparam int MR = 2;

  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_UP    = 2;
  localparam int PH_FAIL  = 3;

  localparam int S_GOOD  = 0;
  localparam int S_FAIL  = 1;
  localparam int S_SLAVE = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       link_up = 1'b0;
  logic       reset_out;
  logic       slave_reset_out;
  logic       link_good;
  logic       link_fail;
  logic [3:0] retry_count;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase, m_age, m_run, m_retries, m_drops;
  bit m_q, m_meta;
  bit m_valid = 1'b0;

  always #5 clock = ~clock;

  c2c_master_reset_seq #(
    .SLAVE_PULSE_CYCLES (SP),
    .LINK_TIMEOUT       (LT),
    .STABLE_CYCLES      (SC),
    .MAX_RETRIES        (MR)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .sw_reset_req    (sw_reset_req),
    .link_up         (link_up),
    .reset_out       (reset_out),
    .slave_reset_out (slave_reset_out),
    .link_good       (link_good),
    .link_fail       (link_fail),
    .retry_count     (retry_count),
    .drop_count      (drop_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: elapsed cycles per phase and run length of synchronized link highs.
  task automatic model_step();
    bit ls;
    ls = m_q;
    if (!resetn) begin
      m_q = 1'b0; m_meta = 1'b0;
    end else begin
      m_q = m_meta; m_meta = link_up;
    end
    if (!resetn) begin
      m_phase = PH_PULSE; m_age = 0; m_run = 0; m_retries = 0; m_drops = 0;
    end else if (sw_reset_req) begin
      m_phase = PH_PULSE; m_age = 0; m_retries = 0;
    end else begin
      case (m_phase)
        PH_PULSE: begin
          m_age++;
          if (m_age == SP) begin m_phase = PH_WAIT; m_age = 0; m_run = 0; end
        end
        PH_WAIT: begin
          m_age++;
          m_run = ls ? m_run + 1 : 0;
          if (m_run == SC) m_phase = PH_UP;
          else if (m_age == LT) begin
            if (m_retries < MR) begin m_retries++; m_phase = PH_PULSE; m_age = 0; end
            else m_phase = PH_FAIL;
          end
        end
        PH_UP: begin
          if (!ls) begin
            m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            m_retries = 0; m_phase = PH_PULSE; m_age = 0;
          end
        end
        default: ;
      endcase
    end
    m_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (m_valid) begin
      check("reset_out",       int'(reset_out),       int'(m_phase == PH_PULSE));
      check("slave_reset_out", int'(slave_reset_out), int'(m_phase == PH_PULSE));
      check("link_good",       int'(link_good),       int'(m_phase == PH_UP));
      check("link_fail",       int'(link_fail),       int'(m_phase == PH_FAIL));
      check("retry_count",     int'(retry_count),     m_retries);
      check("drop_count",      int'(drop_count),      m_drops);
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      S_GOOD:  return link_good;
      S_FAIL:  return link_fail;
      S_SLAVE: return slave_reset_out;
      default: return reset_out;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input bit val,
                          input int limit, output int n);
    n = 0;
    while (sig(sel) != val && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(sig(sel)), int'(val));
  endtask

  task automatic measure_pulse(input string name);
    int n;
    n = 0;
    while (slave_reset_out && n < 50) begin
      @(negedge clock);
      n++;
    end
    check(name, n, 10);
  endtask

  initial begin
    int n, pulses, g, w;
    bit prev;

    // 1: reset 3 cycles, link up at cycle 40
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    check("rst_slave_high", int'(slave_reset_out), 1);
    check("rst_drop_zero", int'(drop_count), 0);
    measure_pulse("pulse_after_reset");
    repeat (27) @(negedge clock);
    link_up = 1'b1;
    wait_sig("lock_reached", S_GOOD, 1'b1, 30, n);
    check("lock_latency", n, 7);
    check("lock_retry", int'(retry_count), 0);

    // 2: link never comes up
    resetn = 1'b0; link_up = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    pulses = 1; prev = slave_reset_out; n = 0;
    while (!link_fail && n < 500) begin
      @(negedge clock);
      n++;
      if (slave_reset_out && !prev) begin
        pulses++;
        check($sformatf("retry_at_pulse%0d", pulses), int'(retry_count), pulses - 1);
      end
      prev = slave_reset_out;
    end
    check("fail_pulses", pulses, 3);
    check("fail_latency", n, 330);
    check("fail_flag", int'(link_fail), 1);
    repeat (200) @(negedge clock);
    check("fail_held", int'(link_fail), 1);
    check("fail_reset_out", int'(reset_out), 0);
    check("fail_retry", int'(retry_count), 2);

    // 3: software restart from FAIL
    sw_reset_req = 1'b1;
    @(negedge clock);
    sw_reset_req = 1'b0;
    check("sw_clears_fail", int'(link_fail), 0);
    check("sw_clears_retry", int'(retry_count), 0);
    measure_pulse("pulse_after_sw");

    // 4: short glitches must not lock
    for (int r = 0; r < 6; r++) begin
      g = (r == 0) ? 3 : int'($urandom_range(1, 4));
      repeat (4) @(negedge clock);
      link_up = 1'b1;
      repeat (g) @(negedge clock);
      link_up = 1'b0;
      repeat (4) @(negedge clock);
      check("glitch_no_lock", int'(link_good), 0);
      link_up = 1'b1;
      wait_sig("lock_after_glitch", S_GOOD, 1'b1, 30, n);
      check("lock_after_glitch_latency", n, 7);
      sw_reset_req = 1'b1; link_up = 1'b0;
      @(negedge clock);
      sw_reset_req = 1'b0;
      measure_pulse("pulse_glitch_round");
    end
    check("no_drop_on_sw", int'(drop_count), 0);
    link_up = 1'b1;
    wait_sig("relock", S_GOOD, 1'b1, 30, n);

    // 5: repeated link drops saturate drop_count
    for (int i = 0; i < 300; i++) begin
      w = int'($urandom_range(1, 3));
      link_up = 1'b0;
      repeat (w) @(negedge clock);
      link_up = 1'b1;
      wait_sig("drop_seen", S_GOOD, 1'b0, 10, n);
      if (i == 0) check("first_drop_count", int'(drop_count), 1);
      wait_sig("drop_relock", S_GOOD, 1'b1, 60, n);
    end
    check("drop_saturated", int'(drop_count), 255);

    // 6a: resetn mid-WAIT after a retry
    link_up = 1'b0;
    wait_sig("6a_pulse", S_SLAVE, 1'b1, 10, n);
    wait_sig("6a_wait", S_SLAVE, 1'b0, 20, n);
    wait_sig("6a_retry_pulse", S_SLAVE, 1'b1, 120, n);
    check("6a_retry_one", int'(retry_count), 1);
    wait_sig("6a_wait2", S_SLAVE, 1'b0, 20, n);
    repeat (20) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("6a_retry_cleared", int'(retry_count), 0);
    check("6a_drop_cleared", int'(drop_count), 0);
    check("6a_pulse_restart", int'(slave_reset_out), 1);

    // 6b: sw_reset_req on the final timeout cycle
    wait_sig("6b_w1", S_SLAVE, 1'b0, 20, n);
    wait_sig("6b_p2", S_SLAVE, 1'b1, 120, n);
    wait_sig("6b_w2", S_SLAVE, 1'b0, 20, n);
    wait_sig("6b_p3", S_SLAVE, 1'b1, 120, n);
    check("6b_retry_two", int'(retry_count), 2);
    wait_sig("6b_w3", S_SLAVE, 1'b0, 20, n);
    repeat (99) @(negedge clock);
    sw_reset_req = 1'b1;
    @(negedge clock);
    sw_reset_req = 1'b0;
    check("6b_no_fail", int'(link_fail), 0);
    check("6b_retry_cleared", int'(retry_count), 0);
    measure_pulse("6b_pulse");

    // Lock completing on the timeout cycle wins
    repeat (93) @(negedge clock);
    link_up = 1'b1;
    wait_sig("edge_lock", S_GOOD, 1'b1, 10, n);
    check("edge_lock_latency", n, 7);
    check("edge_lock_no_pulse", int'(slave_reset_out), 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      resetn = ($urandom_range(0, 499) != 0);
      sw_reset_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) link_up = ~link_up;
    end
    resetn = 1'b1; sw_reset_req = 1'b0;
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
